// File: rtl/sng_array16_if.sv
// Handshake/bus bundle for the sixteen-lane stochastic number generator.
// The master drives start/in_prob. The slave (the generator) returns the stream and status.
interface sng_array16_if #(
  parameter int LANES = 16,
  parameter int WIDTH = 8
);
  logic                     start;
  logic [LANES*WIDTH-1:0]   in_prob;
  logic                     busy;
  logic [LANES-1:0]         out;
  logic                     out_valid;
  logic                     done;

  modport master (output start, in_prob, input busy, out, out_valid, done);
  modport slave  (input start, in_prob, output busy, out, out_valid, done);
endinterface

// File: rtl/sng_array16.sv
// Sixteen-lane unipolar stochastic number generator driven by one shared Galois LFSR.
// Optional macro SNG_DECORR_EN: lane i compares against rn rotated left by (i mod WIDTH).
module sng_array16_lane #(
  parameter int WIDTH = 8,
  parameter int ROT   = 0
) (
  input  logic [WIDTH-1:0] prob_i,
  input  logic [WIDTH-1:0] rn_i,
  output logic             bit_o
);
  logic [2*WIDTH-1:0] rn_dbl;
  logic [WIDTH-1:0]   rn_rot;

  // Rotation keeps rn a bijection of the LFSR state, so full-period counts stay exact.
  always_comb begin
    rn_dbl = {rn_i, rn_i};
    rn_rot = rn_dbl[2*WIDTH-1-ROT -: WIDTH];
    bit_o  = (prob_i > rn_rot);
  end
endmodule

module sng_array16 #(
  parameter int LANES = 16,
  parameter int WIDTH = 8,
  parameter int LEN   = 255,
  parameter int SEED  = 1
) (
  input  logic        clk,
  input  logic        rst,
  sng_array16_if.slave bus
);
  localparam int CW = $clog2(LEN+1);
  localparam logic [CW-1:0]    LAST   = CW'(LEN-1);
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);
  localparam logic [15:0] TAPS16 = (WIDTH == 4)  ? 16'h000C :
                                   (WIDTH == 16) ? 16'hB400 : 16'h00B8;
  localparam logic [WIDTH-1:0] TAPS = TAPS16[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state_q;
  logic [LANES-1:0][WIDTH-1:0]  prob_q;
  logic [LANES-1:0][WIDTH-1:0]  cur_prob;
  logic [WIDTH-1:0]             lfsr_q, cur_lfsr, lfsr_d, rn;
  logic [CW-1:0]                cnt_q;
  logic [LANES-1:0]             out_q, out_d;
  logic                         busy_q, vld_q, done_q;

  // In IDLE the first bit is computed straight from in_prob and SEED so that the
  // registered output appears one cycle after the accepting edge.
  always_comb begin
    cur_prob = (state_q == IDLE) ? bus.in_prob : prob_q;
    cur_lfsr = (state_q == IDLE) ? SEED_V : lfsr_q;
    rn       = cur_lfsr - 1'b1;
    lfsr_d   = cur_lfsr[0] ? ((cur_lfsr >> 1) ^ TAPS) : (cur_lfsr >> 1);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef SNG_DECORR_EN
    localparam int ROT = i % WIDTH;
`else
    localparam int ROT = 0;
`endif
    sng_array16_lane #(.WIDTH(WIDTH), .ROT(ROT)) u_lane (
      .prob_i (cur_prob[i]),
      .rn_i   (rn),
      .bit_o  (out_d[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prob_q  <= '0;
      lfsr_q  <= SEED_V;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= RUN;
            prob_q  <= cur_prob;
            lfsr_q  <= lfsr_d;
            cnt_q   <= '0;
            out_q   <= out_d;
            busy_q  <= 1'b1;
            vld_q   <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == LAST) begin
            state_q <= DONE;
            out_q   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            lfsr_q <= lfsr_d;
            out_q  <= out_d;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_sng_array16.sv
// Scoreboard bench for sng_array16: a reference stream generator fills a queue at each
// accepted start and an independent negedge monitor pops and compares.
module tb_sng_array16;
  localparam int LANES = 16;
  localparam int WIDTH = 8;
  localparam int LEN   = 255;
`ifdef SNG_DECORR_EN
  localparam bit DECORR = 1'b1;
`else
  localparam bit DECORR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sng_array16_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  sng_array16 #(.LANES(LANES), .WIDTH(WIDTH), .LEN(LEN), .SEED(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [LANES-1:0] exp_q[$];
  logic [WIDTH-1:0] probs [LANES];
  int  vld_cnt, done_cnt, subset_viol, diff01;
  int  ones [LANES];
  bit  prev_exp;
  logic [LANES-1:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int r);
    logic [WIDTH-1:0] y;
    y = x;
    for (int k = 0; k < r; k++) y = {y[WIDTH-2:0], y[WIDTH-1]};
    return y;
  endfunction

  // Reference: walk the maximal-length sequence x^8+x^6+x^5+x^4+1 from the seed, rn = state-1.
  task automatic push_run();
    logic [WIDTH-1:0] s, rn, rni;
    logic [LANES-1:0] v;
    s = 8'd1;
    for (int k = 0; k < LEN; k++) begin
      rn = s - 8'd1;
      for (int i = 0; i < LANES; i++) begin
        rni  = DECORR ? rotl(rn, i % WIDTH) : rn;
        v[i] = (probs[i] > rni);
      end
      exp_q.push_back(v);
      s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    end
  endtask

  task automatic drive_probs();
    for (int i = 0; i < LANES; i++) bus.in_prob[i*WIDTH +: WIDTH] = probs[i];
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_exp = 1'b0;
    end else begin
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      chk("busy", bus.busy, exp_q.size() != 0);
      chk("done", bus.done, prev_exp && exp_q.size() == 0);
      prev_exp = (exp_q.size() != 0);
      if (bus.done) done_cnt++;
      if (bus.out_valid) begin
        vld_cnt++;
        for (int i = 0; i < LANES; i++) ones[i] += int'(bus.out[i]);
        if (bus.out[0] && !bus.out[1]) subset_viol++;
        if (bus.out[0] != bus.out[1]) diff01++;
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("stream_bits", bus.out, mon_e);
        end
      end else begin
        chk("out_zero", bus.out, 0);
      end
    end
  end

  // Issues a start, optionally pulses a second start or a reset mid-run, waits for done.
  task automatic run(input int pulse_at, input int abort_at);
    int  dc0;
    bit  fin;
    vld_cnt = 0; subset_viol = 0; diff01 = 0;
    for (int i = 0; i < LANES; i++) ones[i] = 0;
    dc0 = done_cnt;
    fin = 1'b0;
    drive_probs();
    bus.start = 1'b1;
    @(posedge clk);
    push_run();
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc < LEN + 20 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (cyc == pulse_at) begin
        bus.start   = 1'b1;
        bus.in_prob = {$urandom, $urandom, $urandom, $urandom};
      end
      if (cyc == pulse_at + 1) begin
        bus.start = 1'b0;
        drive_probs();
      end
      if (cyc == abort_at) begin
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("no_done_on_abort", done_cnt, dc0);
        fin = 1'b1;
      end else if (done_cnt != dc0) begin
        fin = 1'b1;
      end
    end
    if (!fin) chk("run_timeout", 0, 1);
    if (abort_at < 0) begin
      @(posedge clk); #1;
      chk("valid_count", vld_cnt, LEN);
      chk("done_count", done_cnt - dc0, 1);
      for (int i = 0; i < LANES; i++)
        chk("ones_count", ones[i], int'(probs[i]));
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.in_prob = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    for (int i = 0; i < LANES; i++) probs[i] = 8'h00;
    probs[3] = 8'hFF; probs[7] = 8'h80;
    run(-1, -1);

    for (int i = 0; i < LANES; i++) probs[i] = 8'($urandom);
    probs[0] = 8'h40; probs[1] = 8'hC0;
    run(-1, -1);
    if (!DECORR) chk("subset_correlation", subset_viol, 0);

    for (int i = 0; i < LANES; i++) probs[i] = 8'h55;
    run(-1, -1);
    if (DECORR) chk("lanes_differ", diff01 != 0, 1);
    else        chk("lanes_identical", diff01, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < LANES; i++) probs[i] = 8'($urandom);
      probs[r] = 8'hFF; probs[r+4] = 8'h00; probs[r+8] = 8'h01;
      run(-1, -1);
    end

    for (int i = 0; i < LANES; i++) probs[i] = 8'($urandom);
    run(50, -1);

    run(-1, 100);
    run(-1, -1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
